// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//
// Shared types and default sizes for the program loader that sits in front of
// nand_cpu.
//
// Contents:
//   DEF_INSTR_W   default instruction word width
//   DEF_ADDR_W    default instruction memory address width
//   DEF_RST_HOLD  default number of cycles the CPU reset is held after loading
//   loader_state_t loader FSM states (IDLE, LOAD, HOLD, RUN, ERROR)
//   hold_width()  width of the reset-hold down counter for a given hold length
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_RST_HOLD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  // The hold counter counts 0 .. hold_len-1, so it needs clog2(hold_len)
  // bits; a hold of a single cycle still needs a one-bit register.
  function automatic int hold_width(input int hold_len);
    return (hold_len > 1) ? $clog2(hold_len) : 1;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams an instruction image into nand_cpu's instruction memory, keeps the
// CPU in reset while the image is written, releases it RST_HOLD cycles after
// the final word, and puts it back into reset when it raises halt.
//
// Parameters:
//   INSTR_W   instruction word width
//   ADDR_W    instruction memory address width (capacity 2**ADDR_W words)
//   RST_HOLD  cycles cpu_n_rst stays low after the last write (>= 1)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           begin a new load (honoured in IDLE and ERROR only)
//   s_valid/s_ready/s_data/s_last
//                   instruction stream, one word per handshake
//   imem_we/imem_addr/imem_wdata
//                   instruction memory write port, registered
//   cpu_n_rst       active-low reset to the CPU, high only in RUN
//   cpu_halt        halt indication from the CPU
//   busy            high while loading, holding reset or running
//   done            one-cycle pulse when the CPU halts
//   err             sticky error (overflow or checksum), cleared by start
//   word_count      instructions written in the current / last load
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  when defined, the s_last word is a trailer holding
//                            the sum (mod 2**INSTR_W) of the preceding words;
//                            it is not written and a mismatch goes to ERROR.
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_n_rst,
  input  logic               cpu_halt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    word_count
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = hold_width(RST_HOLD);

  // word_count value at which the memory is full; one more handshake overflows
  localparam logic [CNT_W-1:0]  CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  loader_state_t      state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic               we_reg, we_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [INSTR_W-1:0] wdata_reg, wdata_next;
  logic               err_reg, err_next;
  logic               done_reg, done_next;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] csum_reg, csum_next;
`endif

  logic handshake;
  logic full;
  logic write_word;
  logic clear_load;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      hold_reg  <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  assign handshake = s_valid && (state_reg == LOAD);
  assign full      = (count_reg == CAPACITY);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    hold_next  = '0;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    write_word = 1'b0;
    clear_load = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          clear_load = 1'b1;
        end
      end

      LOAD: begin
        if (handshake) begin
          if (full) begin
            // Every address is already used; drop the word and flag it.
            state_next = ERROR;
            err_next   = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          end else if (s_last) begin
            // Trailer word: compare against the running sum, never written.
            if (s_data == csum_reg) begin
              state_next = HOLD;
            end else begin
              state_next = ERROR;
              err_next   = 1'b1;
            end
`endif
          end else begin
            write_word = 1'b1;
            if (s_last) begin
              state_next = HOLD;
            end
          end
        end
      end

      HOLD: begin
        // hold_reg enters HOLD at zero, so HOLD lasts exactly RST_HOLD cycles.
        if (hold_reg == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end

      RUN: begin
        if (cpu_halt) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      ERROR: begin
        if (start) begin
          state_next = LOAD;
          clear_load = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A new load restarts addressing at zero and forgets the previous outcome.
    if (clear_load) begin
      count_next = '0;
      err_next   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_next  = '0;
`endif
    end

    // The write address is the number of words already written; count_reg is
    // one bit wider so a completely full memory is still distinguishable.
    if (write_word) begin
      we_next    = 1'b1;
      addr_next  = count_reg[ADDR_W-1:0];
      wdata_next = s_data;
      count_next = count_reg + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_next  = csum_reg + s_data;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // These depend only on state_reg, so the asynchronous reset forces them low
  // immediately along with the registered outputs.
  assign s_ready   = (state_reg == LOAD);
  assign cpu_n_rst = (state_reg == RUN);
  assign busy      = (state_reg == LOAD) || (state_reg == HOLD) || (state_reg == RUN);

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader (INSTR_W=16, ADDR_W=2, RST_HOLD=4).
// A reference model turns each stimulus image into the list of words that
// should reach instruction memory and whether the CPU should end up running
// or in error; a monitor records writes, handshakes, reset release and done
// pulses, and each test compares those records with the model.
// Honours PROG_LOADER_CHECKSUM_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int IW  = 16;
  localparam int AW  = 2;
  localparam int RH  = 4;
  localparam int CAP = 1 << AW;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic          s_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          cpu_n_rst;
  logic          cpu_halt;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  prog_loader #(.INSTR_W(IW), .ADDR_W(AW), .RST_HOLD(RH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_n_rst(cpu_n_rst), .cpu_halt(cpu_halt),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  wr_t  wr_q[$];
  int   hs_q[$];
  int   rise_q[$];
  int   done_q[$];
  logic prev_nrst = 1'b0;

  // Stimulus image and model results
  logic [IW-1:0] img      [0:7];
  bit            img_last [0:7];
  int            img_gap  [0:7];
  int            img_len;
  logic [IW-1:0] exp_data [0:7];
  int            exp_nw;
  bit            exp_ok;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation happens on the falling edge, half a cycle from any update.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_q.push_back('{cyc, imem_addr, imem_wdata});
    if (cpu_n_rst === 1'b1 && prev_nrst !== 1'b1) rise_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    prev_nrst <= cpu_n_rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: walk the image word by word applying the loader rules.
  task automatic model_image();
    logic [IW-1:0] sum;
    bit fin;
    sum    = '0;
    exp_nw = 0;
    exp_ok = 1'b0;
    fin    = 1'b0;
    for (int i = 0; i < img_len && !fin; i++) begin
      if (exp_nw == CAP) begin
        fin = 1'b1;                       // overflow: word dropped, error
      end else if (CSUM && img_last[i]) begin
        exp_ok = (img[i] == sum);         // trailer compared, not written
        fin    = 1'b1;
      end else begin
        exp_data[exp_nw] = img[i];
        exp_nw++;
        sum += img[i];
        if (img_last[i]) begin
          exp_ok = 1'b1;
          fin    = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_obs();
    wr_q.delete();
    hs_q.delete();
    rise_q.delete();
    done_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_halt();
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    @(negedge clk);
  endtask

  // Present the image; gap cycles carry junk data with s_valid low.
  task automatic send_image();
    for (int i = 0; i < img_len; i++) begin
      for (int g = 0; g < img_gap[i]; g++) begin
        s_valid = 1'b0;
        s_data  = IW'($urandom);
        s_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = img[i];
      s_last  = img_last[i];
      if (s_ready === 1'b1) hs_q.push_back(cyc);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = IW'($urandom);
  endtask

  task automatic set_image3(input logic [IW-1:0] a, input logic [IW-1:0] b,
                            input logic [IW-1:0] c, input int gap1);
    img_len = 3;
    img[0] = a; img[1] = b; img[2] = c;
    img_last[0] = 1'b0; img_last[1] = 1'b0; img_last[2] = 1'b1;
    img_gap[0] = 0; img_gap[1] = gap1; img_gap[2] = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; cpu_halt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, imem_we, cpu_n_rst, busy, done, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000", {s_ready, imem_we, cpu_n_rst, busy, done, err});
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
      failures++;
      $display("FAIL reset_values addr=%h wdata=%h count=%0d want 0/0/0", imem_addr, imem_wdata, word_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, cpu_n_rst, busy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_outputs got=%b want=000", {s_ready, cpu_n_rst, busy});
    end
  endtask

  task automatic test_basic_load();
    int last_hs;
    clear_obs();
    // 0x3333 is also the sum of the first two, so it is a valid trailer too.
    set_image3(16'h1111, 16'h2222, 16'h3333, 0);
    model_image();
    do_start();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency s_ready=%b busy=%b want 1/1", s_ready, busy);
    end
    send_image();
    repeat (RH + 3) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_nw || hs_q.size() != img_len) begin
      failures++;
      $display("FAIL basic_counts writes=%0d hs=%0d want %0d/%0d", wr_q.size(), hs_q.size(), exp_nw, img_len);
    end
    for (int k = 0; k < wr_q.size() && k < exp_nw && k < hs_q.size(); k++) begin
      checks++;
      if (wr_q[k].addr !== AW'(k) || wr_q[k].data !== exp_data[k] || wr_q[k].cyc != hs_q[k] + 1) begin
        failures++;
        $display("FAIL basic_write[%0d] addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, exp_data[k], hs_q[k] + 1);
      end
    end
    checks++;
    if (word_count !== (AW+1)'(exp_nw)) begin
      failures++;
      $display("FAIL basic_word_count got=%0d want=%0d", word_count, exp_nw);
    end
    last_hs = (hs_q.size() > 0) ? hs_q[hs_q.size()-1] : -1000;
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != last_hs + RH + 1) begin
      failures++;
      $display("FAIL basic_release rises=%0d first=%0d want one at %0d", rise_q.size(),
               (rise_q.size() > 0) ? rise_q[0] : -1, last_hs + RH + 1);
    end
    // start is ignored while running
    do_start();
    checks++;
    if ({cpu_n_rst, busy, s_ready} !== 3'b110) begin
      failures++;
      $display("FAIL run_ignores_start n_rst/busy/s_ready=%b want 110", {cpu_n_rst, busy, s_ready});
    end
  endtask

  task automatic test_halt();
    int c;
    clear_obs();
    c = cyc;
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    checks++;
    if ({done, cpu_n_rst, busy} !== 3'b100) begin
      failures++;
      $display("FAIL halt_response done/n_rst/busy=%b want 100", {done, cpu_n_rst, busy});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_q.size() != 1 || done_q[0] != c + 1) begin
      failures++;
      $display("FAIL done_pulse done=%b pulses=%0d want one pulse at %0d", done, done_q.size(), c + 1);
    end
  endtask

  task automatic test_overflow();
    int bad;
    clear_obs();
    img_len = 5;
    for (int i = 0; i < 5; i++) begin
      img[i] = IW'($urandom); img_last[i] = 1'b0; img_gap[i] = 0;
    end
    model_image();
    do_start();
    send_image();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_n_rst !== 1'b0) bad++;
    end
    checks++;
    if (wr_q.size() != exp_nw) begin
      failures++;
      $display("FAIL overflow_writes got=%0d want=%0d", wr_q.size(), exp_nw);
    end
    for (int k = 0; k < wr_q.size() && k < exp_nw && k < hs_q.size(); k++) begin
      checks++;
      if (wr_q[k].addr !== AW'(k) || wr_q[k].data !== exp_data[k] || wr_q[k].cyc != hs_q[k] + 1) begin
        failures++;
        $display("FAIL overflow_write[%0d] addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, exp_data[k], hs_q[k] + 1);
      end
    end
    checks++;
    if (err !== 1'b1 || bad != 0 || s_ready !== 1'b0 || busy !== 1'b0 || word_count !== (AW+1)'(CAP)) begin
      failures++;
      $display("FAIL overflow_state err=%b n_rst_high_cycles=%0d s_ready=%b busy=%b count=%0d want 1/0/0/0/%0d",
               err, bad, s_ready, busy, word_count, CAP);
    end
    // A new start leaves ERROR and reloads from address 0.
    clear_obs();
    img_len = 2;
    img[0] = 16'h5A5A; img[1] = 16'h5A5A;
    img_last[0] = 1'b0; img_last[1] = 1'b1; img_gap[0] = 0; img_gap[1] = 0;
    model_image();
    do_start();
    checks++;
    if (err !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL error_restart err=%b s_ready=%b want 0/1", err, s_ready);
    end
    send_image();
    repeat (RH + 3) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_nw || wr_q.size() == 0 || wr_q[0].addr !== '0 || rise_q.size() != 1) begin
      failures++;
      $display("FAIL reload_after_error writes=%0d first_addr=%0d rises=%0d want %0d/0/1",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 'x, rise_q.size(), exp_nw);
    end
    do_halt();
  endtask

  task automatic test_reset_mid_load();
    clear_obs();
    img_len = 2;
    img[0] = IW'($urandom); img[1] = IW'($urandom);
    img_last[0] = 1'b0; img_last[1] = 1'b0; img_gap[0] = 0; img_gap[1] = 0;
    do_start();
    send_image();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, imem_we, cpu_n_rst, busy, done, err} !== 6'b0 ||
        imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
      failures++;
      $display("FAIL async_reset flags=%b addr=%h wdata=%h count=%0d want all 0",
               {s_ready, imem_we, cpu_n_rst, busy, done, err}, imem_addr, imem_wdata, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_obs();
    img[0] = 16'h5A5A; img[1] = 16'h5A5A; img_last[1] = 1'b1;
    model_image();
    do_start();
    send_image();
    repeat (RH + 3) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_nw || wr_q.size() == 0 || wr_q[0].addr !== '0 || wr_q[0].data !== exp_data[0]) begin
      failures++;
      $display("FAIL reload_after_reset writes=%0d first_addr=%0d want %0d writes from addr 0",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 'x, exp_nw);
    end
    do_halt();
  endtask

  task automatic test_backpressure();
    clear_obs();
    // C = A + B keeps the image valid when the last word is a trailer.
    set_image3(16'h00A1, 16'h00B2, 16'h0153, 1);
    model_image();
    do_start();
    send_image();
    repeat (RH + 3) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_nw) begin
      failures++;
      $display("FAIL gap_write_count got=%0d want=%0d", wr_q.size(), exp_nw);
    end
    for (int k = 0; k < wr_q.size() && k < exp_nw && k < hs_q.size(); k++) begin
      checks++;
      if (wr_q[k].addr !== AW'(k) || wr_q[k].data !== exp_data[k] || wr_q[k].cyc != hs_q[k] + 1) begin
        failures++;
        $display("FAIL gap_write[%0d] addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, exp_data[k], hs_q[k] + 1);
      end
    end
    do_halt();
  endtask

  task automatic test_checksum();
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      set_image3(16'h0001, 16'hFFFF, IW'(t), 0);
      model_image();
      do_start();
      send_image();
      repeat (RH + 3) @(negedge clk);
      checks++;
      if (wr_q.size() != 2 || {cpu_n_rst, err} !== ((t == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL checksum_trailer%0d writes=%0d n_rst/err=%b want 2 writes and %b",
                 t, wr_q.size(), {cpu_n_rst, err}, (t == 0) ? 2'b10 : 2'b01);
      end
      if (t == 0) do_halt();
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] sum;
    int last_hs;
    for (int it = 0; it < 30; it++) begin
      clear_obs();
      img_len = $urandom_range(1, 5);
      sum = '0;
      for (int i = 0; i < img_len; i++) begin
        img[i]      = IW'($urandom);
        img_last[i] = 1'b0;
        img_gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if (i < img_len - 1) sum += img[i];
      end
      if (img_len <= CAP || $urandom_range(0, 1) == 1) img_last[img_len-1] = 1'b1;
      if (CSUM && $urandom_range(0, 1) == 1) img[img_len-1] = sum;
      model_image();
      do_start();
      checks++;
      if (s_ready !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_start s_ready=%b err=%b want 1/0", it, s_ready, err);
      end
      send_image();
      repeat (RH + 3) @(negedge clk);
      checks++;
      if (wr_q.size() != exp_nw || word_count !== (AW+1)'(exp_nw)) begin
        failures++;
        $display("FAIL rand%0d_counts writes=%0d count=%0d want %0d", it, wr_q.size(), word_count, exp_nw);
      end
      for (int k = 0; k < wr_q.size() && k < exp_nw && k < hs_q.size(); k++) begin
        checks++;
        if (wr_q[k].addr !== AW'(k) || wr_q[k].data !== exp_data[k] || wr_q[k].cyc != hs_q[k] + 1) begin
          failures++;
          $display("FAIL rand%0d_write[%0d] addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   it, k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, exp_data[k], hs_q[k] + 1);
        end
      end
      last_hs = (hs_q.size() > 0) ? hs_q[hs_q.size()-1] : -1000;
      checks++;
      if (exp_ok) begin
        if (rise_q.size() != 1 || rise_q[0] != last_hs + RH + 1 || cpu_n_rst !== 1'b1 || err !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_release rises=%0d n_rst=%b err=%b want release at %0d",
                   it, rise_q.size(), cpu_n_rst, err, last_hs + RH + 1);
        end
        do_halt();
        checks++;
        if (done_q.size() != 1 || cpu_n_rst !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_halt pulses=%0d n_rst=%b busy=%b want 1/0/0", it, done_q.size(), cpu_n_rst, busy);
        end
      end else begin
        if (rise_q.size() != 0 || cpu_n_rst !== 1'b0 || err !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_error rises=%0d n_rst=%b err=%b want 0/0/1", it, rise_q.size(), cpu_n_rst, err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_halt();
    test_overflow();
    test_reset_mid_load();
    test_backpressure();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader sitting directly upstream of `nand_cpu`.
- Accepts an instruction image over a valid/ready stream and writes it word-by-word into the CPU's instruction memory write port.
- Holds the CPU in reset while loading, then releases it.
- Watches `halt` and returns the CPU to reset when the program finishes.
- Replaces backdoor `$readmemb` preloading, so programs can be delivered by a host or bench driver.

## Interface
- `INSTR_W`, 16, instruction word width
- `ADDR_W`, 8, instruction memory address width; capacity 2^ADDR_W words
- `RST_HOLD`, 4, cycles CPU reset stays asserted after the last write (≥1)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a new load (sampled in IDLE/ERROR only)
- `s_valid` in 1: stream word valid
- `s_ready` out 1: loader accepting words
- `s_data` in INSTR_W: instruction word
- `s_last` in 1: final word of image
- `imem_we` out 1: instruction memory write enable
- `imem_addr` out ADDR_W: write address
- `imem_wdata` out INSTR_W: write data
- `cpu_n_rst` out 1: active-low reset to `nand_cpu` (its `n_rst`)
- `cpu_halt` in 1: `nand_cpu` `halt`
- `busy` out 1: high in LOAD, HOLD, RUN
- `done` out 1: one-cycle pulse when CPU halts
- `err` out 1: sticky error flag
- `word_count` out ADDR_W+1: instructions written in current/last load

## Operation
- **States:** IDLE, LOAD, HOLD, RUN, ERROR.
- **IDLE:**
  - `s_ready`=0, `cpu_n_rst`=0.
  - `start` → LOAD; clears address, `word_count`, `err`, checksum.
- **LOAD:**
  - `s_ready`=1.
  - Each handshake (`s_valid & s_ready`) with an instruction word registers a write at the current address, then increments address and `word_count`.
  - A handshake with `s_last`=1 → HOLD.
  - **Overflow:** a handshake when `word_count`==2^ADDR_W → ERROR; the word is not written.
  - `start` is ignored.
- **HOLD:**
  - `s_ready`=0, `cpu_n_rst`=0 for exactly RST_HOLD cycles, then RUN.
- **RUN:**
  - `cpu_n_rst`=1.
  - `cpu_halt`=1 → `done` pulse, → IDLE.
  - `start` and stream input are ignored.
- **ERROR:**
  - `err`=1, `cpu_n_rst`=0, `s_ready`=0.
  - `start` → LOAD, clearing `err`.
- **Reset:** asserting `rst` in any state (including mid-load) → IDLE immediately. Partially written memory contents are left as-is.
- **Address arithmetic:** address is ADDR_W bits; `word_count` is ADDR_W+1 bits, so a full image of 2^ADDR_W words is representable.

## Timing
- **Reset values:**
  - `s_ready`, `imem_we`, `cpu_n_rst`, `busy`, `done`, `err` = 0
  - `imem_addr`, `imem_wdata`, `word_count` = 0
- **Write latency:** handshake at cycle N → `imem_we`/`imem_addr`/`imem_wdata` valid during cycle N+1 only; `word_count` updated at N+1.
- **Throughput:** back-to-back writes, one word per cycle.
- **Release:** `s_last` handshake at N → HOLD from N+1; `cpu_n_rst` rises at N+1+RST_HOLD.
- **Halt:** `cpu_halt` sampled high at N → `done`=1 and `cpu_n_rst`=0 at N+1; `busy`=0 at N+1.
- **Start:** `start` at N in IDLE → `s_ready`=1 at N+1.

## Configuration
- **`PROG_LOADER_CHECKSUM_EN` defined:**
  - The `s_last` word is a trailer, not an instruction, and is not written.
  - It must equal the sum mod 2^INSTR_W of all preceding words; mismatch → ERROR instead of HOLD.
  - A lone `s_last` word is a valid empty image; it passes only if the trailer is 0.
- **Not defined:**
  - The `s_last` word is an ordinary instruction and is written.
  - No checksum logic is present.

## Structure
- **`prog_loader_pkg`:**
  - `loader_state_t` enum (IDLE, LOAD, HOLD, RUN, ERROR)
  - default width constants
- **Sub-modules:** none; the hold counter and checksum accumulator are inline.

## Test plan
- **Basic load:** load 3 words 0x1111, 0x2222, 0x3333 (last on third), RST_HOLD=4 → writes at addr 0,1,2; `word_count`=3; `cpu_n_rst` rises exactly 5 cycles after the `s_last` handshake.
- **Halt:** drive `cpu_halt`=1 in RUN → `done` high 1 cycle, `cpu_n_rst`=0 next cycle, `busy`=0.
- **Overflow:** ADDR_W=2, send 5 words with no `s_last` → 4 writes, `err`=1, `cpu_n_rst` stays 0.
  - A following `start` clears `err` and reloads from addr 0.
- **Reset mid-load:** assert `rst` after 2 words → all outputs return to reset values asynchronously; a later `start` loads from addr 0.
- **Backpressure/gaps:** toggle `s_valid` 1,0,1,1 with data A,-,B,C → writes A,B,C to addr 0,1,2 with no gap-cycle writes.
- **Checksum (`PROG_LOADER_CHECKSUM_EN`):**
  - Words 0x0001, 0xFFFF, trailer 0x0000 → 2 writes, RUN.
  - Same words with trailer 0x0001 → ERROR.
